// File: rtl/pc_fetch_unit.sv
// PC / next-PC fetch stage with start/halt control and retire counters.
// Optional taken-branch/jump counter enabled by PC_FETCH_BRANCH_COUNT_EN.
module pc_fetch_unit #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic [31:0]       instr,
  input  logic              branch_taken,
  input  logic [31:0]       sign_imm,
  output logic [31:0]       pc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              running,
  output logic              halted,
  output logic [31:0]       instr_count,
  output logic [15:0]       branch_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  state_t      state;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        is_jump;
  logic        is_halt;
  logic        retire;

  assign pc_plus4  = pc + 32'd4;
  assign is_jump   = (instr[31:26] == 6'b000010);
  assign is_halt   = (instr == HALT_WORD);
  assign retire    = (state == RUN) && !is_halt && !stall;
  assign imem_addr = pc[ADDR_W+1:2];

  // Jump beats a taken branch when both are flagged.
  always_comb begin
    next_pc = pc_plus4;
    if (is_jump)
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch_taken)
      next_pc = pc_plus4 + {sign_imm[29:0], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr_count <= 32'd0;
      running     <= 1'b0;
      halted      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (is_halt) begin
            state   <= HALT;
            running <= 1'b0;
            halted  <= 1'b1;
          end else if (!stall) begin
            pc <= {next_pc[31:2], 2'b00};
            if (instr_count != 32'hFFFF_FFFF)
              instr_count <= instr_count + 32'd1;
          end
        end
        HALT: begin
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_FETCH_BRANCH_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      branch_count <= 16'd0;
    else if (retire && (is_jump || branch_taken) &&
             branch_count != 16'hFFFF)
      branch_count <= branch_count + 16'd1;
  end
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign branch_count  = 16'h0;
`endif

endmodule
